apb_mem_slave_p: RTL and testbench

//  Parametrised APB memory slave; next generation of the team's single-byte APB slave.

---
 rtl/apb_mem_slave_p.sv | 193 +++++++++++++++++++
 tb/tb_apb_mem_slave_p.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave_p.sv
// -----------------------------------------------------------------------------
// apb_mem_slave_p
//
// Parametrised APB memory slave. One instance sits behind each PSELx output
// of the APB decoder. It provides a word-addressed memory with per-byte write
// strobes, a programmable number of PREADY-low wait cycles per transfer, and
// an error response (PSLVERR) for addresses beyond the implemented depth.
// All outputs come straight from flops.
//
// Parameters
//   ADDR_WIDTH   word address width
//   DATA_WIDTH   data width, multiple of 8
//   DEPTH        implemented words, DEPTH <= 2**ADDR_WIDTH
//   WAIT_STATES  PREADY-low access cycles per transfer (0..15)
//
// Ports
//   pclk_i      in   clock, everything on the rising edge
//   preset_ni   in   asynchronous active-low reset
//   pselect_i   in   slave select
//   penable_i   in   access phase
//   pwrite_i    in   1 = write, 0 = read
//   paddr_i     in   word address
//   pwdata_i    in   write data
//   pstrb_i     in   write byte-lane enables (ignored on reads)
//   prdata_o    out  read data, valid with pready_o on a read
//   pready_o    out  transfer completes in this cycle
//   pslverr_o   out  error response, only ever high together with pready_o
// -----------------------------------------------------------------------------
module apb_mem_slave_p #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 0
) (
  input  logic                    pclk_i,
  input  logic                    preset_ni,
  input  logic                    pselect_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH fits in ADDR_WIDTH+1 bits because DEPTH <= 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READY
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

  logic                    addr_oob;
  logic [IDX_W-1:0]        mem_idx;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    mem_we;
  logic                    enter_ready;

  // Range check on the live address; the master keeps PADDR stable for the
  // whole transfer, so it is valid both at setup and at completion.
  assign addr_oob = ({1'b0, paddr_i} >= DEPTH_C);

  // Out-of-range addresses are steered to word 0 so the array is never
  // indexed past its end; the data is discarded in that case anyway.
  assign mem_idx = addr_oob ? '0 : paddr_i[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // Storage: one 8-bit array per byte lane so each strobe maps onto its own
  // write enable. Contents deliberately have no reset and survive preset_ni.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH];

      always_ff @(posedge pclk_i) begin
        if (mem_we && pstrb_i[gi]) begin
          mem_q[mem_idx] <= pwdata_i[gi*8 +: 8];
        end
      end

      assign rd_word[gi*8 +: 8] = mem_q[mem_idx];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM next state and registered-output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = prdata_q;
    mem_we      = 1'b0;
    enter_ready = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Only a genuine setup phase starts a transfer; PENABLE high
        // without a preceding setup is ignored.
        if (pselect_i && !penable_i) begin
          err_d = addr_oob;
          if (WAIT_STATES == 0) begin
            enter_ready = 1'b1;
          end else begin
            cnt_d   = 4'(WAIT_STATES);
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (!pselect_i) begin
          // Master abandoned the transfer.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (penable_i) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            enter_ready = 1'b1;
          end
        end
      end

      S_READY: begin
        // PREADY is high for this single cycle only. The write commits on
        // the edge that closes it, and only if the master is still in the
        // access phase and the address was in range.
        state_d = S_IDLE;
        cnt_d   = '0;
        if (pselect_i && penable_i && pwrite_i && !err_q) begin
          mem_we = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (enter_ready) begin
      state_d   = S_READY;
      pready_d  = 1'b1;
      pslverr_d = err_d;
      // Reads load PRDATA as READY is entered; writes leave it untouched.
      if (!pwrite_i) begin
        prdata_d = err_d ? '0 : rd_word;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign prdata_o  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// -----------------------------------------------------------------------------
// tb_apb_mem_slave_p
//
// Two slaves share one APB bus: A is 32-bit, 100 words deep, 3 wait states
// (addresses 100..127 are out of range); B is 8-bit, 128 words, no wait
// states. The driver computes each transfer's expected response from a plain
// array model at setup time and queues it; per-slave monitors pop and compare
// whenever PREADY is seen, including the cycle on which it arrives.
// -----------------------------------------------------------------------------
module tb_apb_mem_slave_p;

  localparam int AW     = 7;
  localparam int DEPTHA = 100;
  localparam int WSA    = 3;
  localparam int DEPTHB = 128;
  localparam int WSB    = 0;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel  = 1'b0;
  logic        pen   = 1'b0;
  logic        pwr   = 1'b0;
  logic [AW-1:0] paddr  = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb  = '0;

  logic [31:0] a_prdata;
  logic        a_pready, a_pslverr;
  logic [7:0]  b_prdata;
  logic        b_pready, b_pslverr;

  always #5 clk = ~clk;

  apb_mem_slave_p #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .DEPTH(DEPTHA), .WAIT_STATES(WSA)
  ) u_dut_a (
    .pclk_i(clk), .preset_ni(rst_n), .pselect_i(psel), .penable_i(pen),
    .pwrite_i(pwr), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(a_prdata), .pready_o(a_pready), .pslverr_o(a_pslverr)
  );

  apb_mem_slave_p #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(8), .DEPTH(DEPTHB), .WAIT_STATES(WSB)
  ) u_dut_b (
    .pclk_i(clk), .preset_ni(rst_n), .pselect_i(psel), .penable_i(pen),
    .pwrite_i(pwr), .paddr_i(paddr), .pwdata_i(pwdata[7:0]), .pstrb_i(pstrb[0:0]),
    .prdata_o(b_prdata), .pready_o(b_pready), .pslverr_o(b_pslverr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  // Reference model: plain word arrays plus the last value each slave
  // returned on a read (PRDATA holds it across writes).
  logic [31:0] mem_a [DEPTHA];
  logic [7:0]  mem_b [DEPTHB];
  logic [31:0] last_a = '0;
  logic [7:0]  last_b = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (!a_pready) begin
        check("A pslverr without pready", 32'(a_pslverr), 32'd0);
      end else if (qa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL A spurious pready: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        ea = qa.pop_front();
        check("A pready cycle", 32'(cyc), 32'(ea.due));
        check("A pslverr", 32'(a_pslverr), 32'(ea.err));
        check("A prdata", a_prdata, ea.rdata);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (!b_pready) begin
        check("B pslverr without pready", 32'(b_pslverr), 32'd0);
      end else if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL B spurious pready: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        eb = qb.pop_front();
        check("B pready cycle", 32'(cyc), 32'(eb.due));
        check("B pslverr", 32'(b_pslverr), 32'(eb.err));
        check("B prdata", {24'h0, b_prdata}, eb.rdata);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver. mode: 0 normal, 1 reset during A's wait, 2 PSELECT dropped during
  // A's wait, 3 reset during A's READY cycle (write is lost).
  // Slave B always finishes first, so only slave A is affected by modes 1..3.
  // ---------------------------------------------------------------------------
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("A pready after reset", 32'(a_pready), 32'd0);
    check("A pslverr after reset", 32'(a_pslverr), 32'd0);
    check("A prdata after reset", a_prdata, 32'd0);
    check("B prdata after reset", {24'h0, b_prdata}, 32'd0);
    last_a = '0;
    last_b = '0;
    psel = 1'b0;
    pen  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int mode);
    exp_t e;
    logic oob;
    logic seen;
    @(posedge clk); #1;
    psel = 1'b1; pen = 1'b0; pwr = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    $display("[TB] %s addr=%0d wdata=%h strb=%b mode=%0d cycle=%0d",
             wr ? "WR" : "RD", addr, wdata, strb, mode, cyc);

    oob = (int'(addr) >= DEPTHA);
    if (mode == 0 || mode == 3) begin
      e.due = cyc + 1 + WSA;
      e.err = oob;
      if (wr) begin
        e.rdata = last_a;
        if (!oob && mode == 0) begin
          for (int l = 0; l < 4; l++) begin
            if (strb[l]) mem_a[int'(addr)][l*8 +: 8] = wdata[l*8 +: 8];
          end
        end
      end else begin
        e.rdata = oob ? 32'h0 : mem_a[int'(addr)];
        last_a  = e.rdata;
      end
      qa.push_back(e);
    end

    e.due = cyc + 1 + WSB;
    e.err = 1'b0;
    if (wr) begin
      e.rdata = {24'h0, last_b};
      if (strb[0]) mem_b[int'(addr)] = wdata[7:0];
    end else begin
      last_b  = mem_b[int'(addr)];
      e.rdata = {24'h0, last_b};
    end
    qb.push_back(e);

    @(posedge clk); #1;
    pen = 1'b1;

    if (mode == 1 || mode == 2) begin
      @(posedge clk); #1;
      if (mode == 1) begin
        reset_pulse();
      end else begin
        psel = 1'b0;
        pen  = 1'b0;
      end
    end else begin
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        seen = a_pready;
      end
      check("A pready within budget", 32'(seen), 32'd1);
      if (!seen) begin
        psel = 1'b0;
        pen  = 1'b0;
      end
      if (mode == 3) begin
        #1;
        reset_pulse();
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel = 1'b0;
    pen  = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("A reset pready", 32'(a_pready), 32'd0);
    check("A reset pslverr", 32'(a_pslverr), 32'd0);
    check("A reset prdata", a_prdata, 32'd0);
    check("B reset pready", 32'(b_pready), 32'd0);
    check("B reset pslverr", 32'(b_pslverr), 32'd0);
    check("B reset prdata", {24'h0, b_prdata}, 32'd0);
    rst_n = 1'b1;

    // Give every word a known value (A: 100..127 answer with an error).
    for (int i = 0; i < DEPTHB; i++) xfer(1'b1, AW'(i), $urandom, 4'hF, 0);
    idle();

    // Single byte write/read.
    xfer(1'b1, 7'h10, 32'h0000_005A, 4'hF, 0);
    xfer(1'b0, 7'h10, 32'h0, 4'h0, 0);
    idle();

    // Partial strobes merge lanes.
    xfer(1'b1, 7'd20, 32'hAABB_CCDD, 4'hF, 0);
    xfer(1'b1, 7'd20, 32'h1122_3344, 4'b0101, 0);
    xfer(1'b0, 7'd20, 32'h0, 4'h0, 0);
    xfer(1'b1, 7'd20, 32'hFFFF_FFFF, 4'h0, 0);
    xfer(1'b0, 7'd20, 32'h0, 4'hF, 0);
    idle();

    // Range boundary on A.
    xfer(1'b1, 7'd100, 32'h0000_0077, 4'hF, 0);
    xfer(1'b0, 7'd100, 32'h0, 4'h0, 0);
    xfer(1'b0, 7'd99, 32'h0, 4'h0, 0);
    xfer(1'b0, 7'd127, 32'h0, 4'h0, 0);
    idle();

    // Back-to-back with no idle cycle.
    xfer(1'b1, 7'd3, 32'hC0DE_0003, 4'hF, 0);
    xfer(1'b0, 7'd3, 32'h0, 4'h0, 0);
    xfer(1'b1, 7'd4, 32'hBEEF_0004, 4'hF, 0);
    xfer(1'b0, 7'd4, 32'h0, 4'h0, 0);
    idle();

    // Aborts: reset and deselect during the wait, reset during READY.
    xfer(1'b1, 7'd5, 32'h0000_0033, 4'hF, 1);
    xfer(1'b0, 7'd5, 32'h0, 4'h0, 0);
    xfer(1'b1, 7'd6, 32'h0000_0044, 4'hF, 2);
    xfer(1'b0, 7'd6, 32'h0, 4'h0, 0);
    xfer(1'b1, 7'd7, 32'h0000_0055, 4'hF, 3);
    xfer(1'b0, 7'd7, 32'h0, 4'h0, 0);
    idle();

    // PENABLE high without a setup phase must not start anything.
    @(posedge clk); #1;
    psel = 1'b1; pen = 1'b1; pwr = 1'b1; paddr = 7'd8; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    psel = 1'b0; pen = 1'b0;
    xfer(1'b0, 7'd8, 32'h0, 4'h0, 0);
    idle();

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      logic          wr;
      logic [AW-1:0] addr;
      int            mode;
      int            r;
      wr   = 1'($urandom_range(0, 1));
      addr = AW'($urandom_range(0, 127));
      r    = int'($urandom_range(0, 99));
      mode = 0;
      if (r < 3) mode = 1;
      else if (r < 6) mode = 2;
      else if (r < 9 && wr) mode = 3;
      xfer(wr, addr, $urandom, 4'($urandom_range(0, 15)), mode);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    repeat (6) @(posedge clk);
    #1;
    check("A expected responses drained", 32'(qa.size()), 32'd0);
    check("B expected responses drained", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
